multicycle_control_unit: RTL

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//
// Moore-style control FSM for a MIPS-like multicycle datapath. Each
// instruction is fetched, decoded and then walked through a short chain of
// states that steer the shared ALU, memory port, register file and PC mux.
// An arithmetic overflow or an undefined opcode diverts into EXCEPTION,
// which saves the already-incremented PC into EPC and jumps to vector 0.
//
// Ports
//   CLK       in   clock, all state changes on the rising edge
//   RST       in   asynchronous active-low reset (forces FETCH)
//   Opcode    in   Instr[31:26] from the instruction register
//   Funct     in   Instr[5:0]
//   Zero      in   ALU zero flag (current cycle)
//   Overflow  in   ALU signed overflow (current cycle)
//   PC_LOAD   out  write enable for the PC
//   IorD      out  memory address select: 0 = PC, 1 = ALU_REG_OUT
//   IR_EN     out  instruction register load
//   EPC_EN    out  exception PC load
//   MemRead   out  memory read strobe
//   MemWrite  out  memory write strobe
//   RegWrite  out  register file write enable
//   RegDst    out  destination select: 0 = rt, 1 = rd
//   MemtoReg  out  write-back data: 0 = ALU_REG_OUT, 1 = memory data
//   ALUSrcA   out  ALU A operand: 0 = PC, 1 = reg A
//   PC_SEL    out  next PC: 0 ALU_OUT, 1 ALU_REG_OUT, 2 jump, 3 Reg1_Out, 4 vector 0
//   ALUSrcB   out  ALU B operand: 0 reg B, 1 const 4, 2 sext imm, 3 sext imm << 2
//   ALUOp     out  0 add, 1 subtract, 2 decode by Funct
//   STATE     out  current state code (debug)
// ---------------------------------------------------------------------------
module multicycle_control_unit (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       Overflow,
  output logic       PC_LOAD,
  output logic       IorD,
  output logic       IR_EN,
  output logic       EPC_EN,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [2:0] PC_SEL,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] STATE
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11,
    JR        = 4'd12,
    EXCEPTION = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] PCS_ALU     = 3'd0;
  localparam logic [2:0] PCS_ALU_REG = 3'd1;
  localparam logic [2:0] PCS_JUMP    = 3'd2;
  localparam logic [2:0] PCS_REG1    = 3'd3;
  localparam logic [2:0] PCS_VECTOR  = 3'd4;

  localparam logic [1:0] SRCB_REG   = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  state_t state_r;
  state_t next_s;

  // State register; reset holds the machine in FETCH regardless of the clock.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state selection. Unused codes 14/15 fall through to FETCH.
  always_comb begin
    next_s = FETCH;
    case (state_r)
      FETCH: begin
        next_s = DECODE;
      end
      DECODE: begin
        if ((Opcode == OP_LW) || (Opcode == OP_SW)) begin
          next_s = MEM_ADDR;
        end else if (Opcode == OP_RTYPE) begin
          if (Funct == FN_JR) begin
            next_s = JR;
          end else begin
            next_s = EXECUTE;
          end
        end else if ((Opcode == OP_BEQ) || (Opcode == OP_BNE)) begin
          next_s = BRANCH;
        end else if (Opcode == OP_J) begin
          next_s = JUMP;
        end else if (Opcode == OP_ADDI) begin
          next_s = ADDI_EXEC;
        end else begin
          next_s = EXCEPTION;
        end
      end
      MEM_ADDR: begin
        if (Opcode == OP_LW) begin
          next_s = MEM_READ;
        end else begin
          next_s = MEM_WRITE;
        end
      end
      MEM_READ:  next_s = MEM_WB;
      MEM_WB:    next_s = FETCH;
      MEM_WRITE: next_s = FETCH;
      EXECUTE: begin
        // Overflow skips the write-back so the destination register is untouched.
        if (Overflow) begin
          next_s = EXCEPTION;
        end else begin
          next_s = ALU_WB;
        end
      end
      ALU_WB:    next_s = FETCH;
      BRANCH:    next_s = FETCH;
      JUMP:      next_s = FETCH;
      ADDI_EXEC: begin
        if (Overflow) begin
          next_s = EXCEPTION;
        end else begin
          next_s = ADDI_WB;
        end
      end
      ADDI_WB:   next_s = FETCH;
      JR:        next_s = FETCH;
      EXCEPTION: next_s = FETCH;
      default:   next_s = FETCH;
    endcase
  end

  // Output decode from the current state; only the branch PC_LOAD looks at inputs.
  always_comb begin
    PC_LOAD  = 1'b0;
    IorD     = 1'b0;
    IR_EN    = 1'b0;
    EPC_EN   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    PC_SEL   = PCS_ALU;
    ALUSrcB  = SRCB_REG;
    ALUOp    = ALU_ADD;
    case (state_r)
      FETCH: begin
        // PC + 4 goes straight from the ALU into the PC while the IR loads.
        MemRead = 1'b1;
        IR_EN   = 1'b1;
        ALUSrcB = SRCB_FOUR;
        PC_SEL  = PCS_ALU;
        PC_LOAD = 1'b1;
      end
      DECODE: begin
        // Speculative branch target PC + (imm << 2) into ALU_REG_OUT.
        ALUSrcB = SRCB_IMMSH;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      ALU_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        // Compare A - B; the target was already latched during DECODE.
        ALUSrcA = 1'b1;
        ALUOp   = ALU_SUB;
        PC_SEL  = PCS_ALU_REG;
        if (Opcode == OP_BEQ) begin
          PC_LOAD = Zero;
        end else if (Opcode == OP_BNE) begin
          PC_LOAD = ~Zero;
        end else begin
          PC_LOAD = 1'b0;
        end
      end
      JUMP: begin
        PC_SEL  = PCS_JUMP;
        PC_LOAD = 1'b1;
      end
      ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      ADDI_WB: begin
        RegWrite = 1'b1;
      end
      JR: begin
        PC_SEL  = PCS_REG1;
        PC_LOAD = 1'b1;
      end
      EXCEPTION: begin
        // The PC still holds faulting address + 4 here, which is what EPC keeps.
        EPC_EN  = 1'b1;
        PC_SEL  = PCS_VECTOR;
        PC_LOAD = 1'b1;
      end
      default: begin
        PC_LOAD = 1'b0;
      end
    endcase
  end

  assign STATE = state_r;

endmodule
